// File: rtl/vram_pkg.sv
// Shared types and default geometry for the VGA framebuffer arbiter.
package vram_pkg;

  localparam int VRAM_DEPTH  = 19200;
  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 3;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  // Owner of the read issued last cycle, so the RAM output reaches the right port.
  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_DISP,
    TAG_HOST
  } tag_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Display, host and clear-engine signals between the drawing/scanout side and the arbiter.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
);

  logic              i_Disp_Req;
  logic [ADDR_W-1:0] i_Disp_Addr;
  logic              o_Disp_Valid;
  logic [DATA_W-1:0] o_Disp_Data;

  logic              i_Host_Valid;
  logic              o_Host_Ready;
  logic              i_Host_We;
  logic [ADDR_W-1:0] i_Host_Addr;
  logic [DATA_W-1:0] i_Host_Wdata;
  logic              o_Host_Rvalid;
  logic [DATA_W-1:0] o_Host_Rdata;

  logic              i_Clear_Start;
  logic [DATA_W-1:0] i_Clear_Color;
  logic              o_Clear_Busy;
  logic              o_Clear_Done;

  modport master (
    output i_Disp_Req, i_Disp_Addr,
    input  o_Disp_Valid, o_Disp_Data,
    output i_Host_Valid, i_Host_We, i_Host_Addr, i_Host_Wdata,
    input  o_Host_Ready, o_Host_Rvalid, o_Host_Rdata,
    output i_Clear_Start, i_Clear_Color,
    input  o_Clear_Busy, o_Clear_Done
  );

  modport slave (
    input  i_Disp_Req, i_Disp_Addr,
    output o_Disp_Valid, o_Disp_Data,
    input  i_Host_Valid, i_Host_We, i_Host_Addr, i_Host_Wdata,
    output o_Host_Ready, o_Host_Rvalid, o_Host_Rdata,
    input  i_Clear_Start, i_Clear_Color,
    output o_Clear_Busy, o_Clear_Done
  );

endinterface

// File: rtl/vram_bram.sv
// Single-port framebuffer RAM with one-cycle registered read; no reset so it maps onto block RAM.
module vram_bram #(
  parameter int DEPTH  = 19200,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the framebuffer port: display fetches first, then the clear engine, then the host.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int DEPTH  = VRAM_DEPTH,
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input logic           i_Clk,
  input logic           i_Rst_n,
  vram_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clearAddr_q, clearAddr_d;
  logic [DATA_W-1:0] clearColor_q, clearColor_d;
  logic              done_q, done_d;
  tag_t              tag_q, tag_d;
  logic              oob_q, oob_d;
  logic [DATA_W-1:0] dispHold_q, hostHold_q;

  logic              ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramWdata, ramRdata, retData;
  logic              hostReady, hostFire, clearWrite, lastClear;

  function automatic logic inRange(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(DEPTH);
  endfunction

  assign hostReady  = (state_q == ST_IDLE) && !bus.i_Disp_Req;
  assign hostFire   = bus.i_Host_Valid && hostReady;
  assign clearWrite = (state_q == ST_CLEAR) && !bus.i_Disp_Req;
  assign lastClear  = clearWrite && (clearAddr_q == ADDR_W'(DEPTH - 1));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= ST_IDLE;
      clearAddr_q  <= '0;
      clearColor_q <= '0;
      done_q       <= 1'b0;
      tag_q        <= TAG_NONE;
      oob_q        <= 1'b0;
      dispHold_q   <= '0;
      hostHold_q   <= '0;
    end else begin
      state_q      <= state_d;
      clearAddr_q  <= clearAddr_d;
      clearColor_q <= clearColor_d;
      done_q       <= done_d;
      tag_q        <= tag_d;
      oob_q        <= oob_d;
      if (tag_q == TAG_DISP) dispHold_q <= retData;
      if (tag_q == TAG_HOST) hostHold_q <= retData;
    end
  end

  always_comb begin
    state_d      = state_q;
    clearAddr_d  = clearAddr_q;
    clearColor_d = clearColor_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_Clear_Start) begin
          state_d      = ST_CLEAR;
          clearAddr_d  = '0;
          clearColor_d = bus.i_Clear_Color;
        end
      end
      ST_CLEAR: begin
        if (clearWrite) begin
          clearAddr_d = clearAddr_q + ADDR_W'(1);
          if (lastClear) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Out-of-range writes are dropped here; out-of-range reads are tagged and return zero.
  always_comb begin
    ramWe    = 1'b0;
    ramAddr  = clearAddr_q;
    ramWdata = clearColor_q;
    tag_d    = TAG_NONE;
    oob_d    = 1'b0;
    if (bus.i_Disp_Req) begin
      ramAddr = bus.i_Disp_Addr;
      tag_d   = TAG_DISP;
      oob_d   = !inRange(bus.i_Disp_Addr);
    end else if (state_q == ST_CLEAR) begin
      ramWe = 1'b1;
    end else if (hostFire) begin
      ramAddr  = bus.i_Host_Addr;
      ramWdata = bus.i_Host_Wdata;
      if (bus.i_Host_We) begin
        ramWe = inRange(bus.i_Host_Addr);
      end else begin
        tag_d = TAG_HOST;
        oob_d = !inRange(bus.i_Host_Addr);
      end
    end
  end

  vram_bram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_bram (
    .clk    (i_Clk),
    .we_i   (ramWe),
    .addr_i (ramAddr),
    .wdata_i(ramWdata),
    .rdata_o(ramRdata)
  );

  assign retData = oob_q ? '0 : ramRdata;

  assign bus.o_Host_Ready  = hostReady;
  assign bus.o_Disp_Valid  = (tag_q == TAG_DISP);
  assign bus.o_Disp_Data   = (tag_q == TAG_DISP) ? retData : dispHold_q;
  assign bus.o_Host_Rvalid = (tag_q == TAG_HOST);
  assign bus.o_Host_Rdata  = (tag_q == TAG_HOST) ? retData : hostHold_q;
  assign bus.o_Clear_Busy  = (state_q == ST_CLEAR);
  assign bus.o_Clear_Done  = done_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter: handshake, priority, clear engine and range handling.
module tb_vram_arbiter;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;
  logic [2:0] model [0:127];

  vram_arbiter_if #(.ADDR_W(15), .DATA_W(3)) bus ();

  vram_arbiter #(.DEPTH(19200), .ADDR_W(15), .DATA_W(3)) dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One host command presented for a single cycle while the port is known to be free.
  task automatic hostOp(input logic we, input logic [14:0] addr, input logic [2:0] data);
    bus.i_Host_Valid = 1'b1;
    bus.i_Host_We    = we;
    bus.i_Host_Addr  = addr;
    bus.i_Host_Wdata = data;
    tick();
    bus.i_Host_Valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_Disp_Req = 1'b0; bus.i_Disp_Addr = '0;
    bus.i_Host_Valid = 1'b0; bus.i_Host_We = 1'b0; bus.i_Host_Addr = '0; bus.i_Host_Wdata = '0;
    bus.i_Clear_Start = 1'b0; bus.i_Clear_Color = '0;
    #1;
    testsRun++; if (bus.o_Disp_Valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_disp_valid: got %0b expected 0", bus.o_Disp_Valid); end
    testsRun++; if (bus.o_Host_Rvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_host_rvalid: got %0b expected 0", bus.o_Host_Rvalid); end
    testsRun++; if (bus.o_Clear_Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %0b expected 0", bus.o_Clear_Busy); end
    testsRun++; if (bus.o_Clear_Done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %0b expected 0", bus.o_Clear_Done); end
    testsRun++; if (bus.o_Disp_Data !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_disp_data: got %0h expected 0", bus.o_Disp_Data); end
    testsRun++; if (bus.o_Host_Rdata !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_host_rdata: got %0h expected 0", bus.o_Host_Rdata); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    testsRun++; if (bus.o_Host_Ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL idle_ready: got %0b expected 1", bus.o_Host_Ready); end
    testsRun++; if (bus.o_Clear_Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_busy: got %0b expected 0", bus.o_Clear_Busy); end
  endtask

  task automatic test_host_rw();
    hostOp(1'b1, 15'd5, 3'b101);
    model[5] = 3'b101;
    testsRun++; if (bus.o_Host_Rvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL write_no_rvalid: got %0b expected 0", bus.o_Host_Rvalid); end
    hostOp(1'b0, 15'd5, 3'd0);
    testsRun++; if (bus.o_Host_Rvalid !== 1'b1) begin testsFailed++; $display("[TB] FAIL read5_rvalid: got %0b expected 1", bus.o_Host_Rvalid); end
    testsRun++; if (bus.o_Host_Rdata !== 3'b101) begin testsFailed++; $display("[TB] FAIL read5_data: got %0h expected 5", bus.o_Host_Rdata); end
    tick();
    testsRun++; if (bus.o_Host_Rvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL read5_rvalid_drop: got %0b expected 0", bus.o_Host_Rvalid); end
    testsRun++; if (bus.o_Host_Rdata !== 3'b101) begin testsFailed++; $display("[TB] FAIL read5_hold: got %0h expected 5", bus.o_Host_Rdata); end
  endtask

  task automatic test_disp_priority();
    bus.i_Disp_Req = 1'b1; bus.i_Disp_Addr = 15'd5;
    bus.i_Host_Valid = 1'b1; bus.i_Host_We = 1'b1; bus.i_Host_Addr = 15'd6; bus.i_Host_Wdata = 3'b011;
    for (int i = 0; i < 5; i++) begin
      #1;
      testsRun++; if (bus.o_Host_Ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL prio_ready[%0d]: got %0b expected 0", i, bus.o_Host_Ready); end
      tick();
      testsRun++; if (bus.o_Disp_Valid !== 1'b1 || bus.o_Disp_Data !== 3'b101) begin testsFailed++; $display("[TB] FAIL prio_disp[%0d]: got valid %0b data %0h expected 1/5", i, bus.o_Disp_Valid, bus.o_Disp_Data); end
    end
    bus.i_Disp_Req = 1'b0;
    #1;
    testsRun++; if (bus.o_Host_Ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL prio_release_ready: got %0b expected 1", bus.o_Host_Ready); end
    tick();
    bus.i_Host_Valid = 1'b0;
    model[6] = 3'b011;
    hostOp(1'b0, 15'd6, 3'd0);
    testsRun++; if (bus.o_Host_Rdata !== 3'b011) begin testsFailed++; $display("[TB] FAIL prio_write6: got %0h expected 3", bus.o_Host_Rdata); end
  endtask

  task automatic test_back_to_back();
    int w;
    logic dispNow, hostAcc;
    logic [2:0] expDisp;
    w = 0;
    for (int c = 0; c < 400 && w < 100; c++) begin
      dispNow = (c % 4 == 0);
      bus.i_Disp_Req   = dispNow;
      bus.i_Disp_Addr  = (w > 0) ? 15'(w - 1) : 15'd5;
      bus.i_Host_Valid = 1'b1; bus.i_Host_We = 1'b1;
      bus.i_Host_Addr  = 15'(w); bus.i_Host_Wdata = 3'(w);
      hostAcc = !dispNow;
      expDisp = model[(w > 0) ? (w - 1) : 5];
      #1;
      testsRun++; if (bus.o_Host_Ready !== hostAcc) begin testsFailed++; $display("[TB] FAIL stream_ready[%0d]: got %0b expected %0b", c, bus.o_Host_Ready, hostAcc); end
      tick();
      if (hostAcc) begin model[w] = 3'(w); w++; end
      testsRun++; if (bus.o_Disp_Valid !== dispNow) begin testsFailed++; $display("[TB] FAIL stream_disp_valid[%0d]: got %0b expected %0b", c, bus.o_Disp_Valid, dispNow); end
      if (dispNow) begin
        testsRun++; if (bus.o_Disp_Data !== expDisp) begin testsFailed++; $display("[TB] FAIL stream_disp_data[%0d]: got %0h expected %0h", c, bus.o_Disp_Data, expDisp); end
      end
    end
    bus.i_Disp_Req = 1'b0; bus.i_Host_Valid = 1'b0;
    hostOp(1'b0, 15'd0, 3'd0);
    testsRun++; if (bus.o_Host_Rdata !== 3'd0) begin testsFailed++; $display("[TB] FAIL stream_rd0: got %0h expected 0", bus.o_Host_Rdata); end
    hostOp(1'b0, 15'd37, 3'd0);
    testsRun++; if (bus.o_Host_Rdata !== 3'd5) begin testsFailed++; $display("[TB] FAIL stream_rd37: got %0h expected 5", bus.o_Host_Rdata); end
    hostOp(1'b0, 15'd99, 3'd0);
    testsRun++; if (bus.o_Host_Rdata !== 3'd3) begin testsFailed++; $display("[TB] FAIL stream_rd99: got %0h expected 3", bus.o_Host_Rdata); end
  endtask

  task automatic test_clear();
    int n;
    logic [14:0] addrs [4];
    addrs = '{15'd0, 15'd777, 15'd12345, 15'd19199};
    bus.i_Clear_Start = 1'b1; bus.i_Clear_Color = 3'b010;
    tick();
    bus.i_Clear_Start = 1'b0; bus.i_Clear_Color = 3'b000;
    n = 0;
    while (bus.o_Clear_Busy === 1'b1 && n < 25000) begin
      n++;
      tick();
    end
    testsRun++; if (n != 19200) begin testsFailed++; $display("[TB] FAIL clear_busy_cycles: got %0d expected 19200", n); end
    testsRun++; if (bus.o_Clear_Done !== 1'b1) begin testsFailed++; $display("[TB] FAIL clear_done_pulse: got %0b expected 1", bus.o_Clear_Done); end
    tick();
    testsRun++; if (bus.o_Clear_Done !== 1'b0) begin testsFailed++; $display("[TB] FAIL clear_done_single: got %0b expected 0", bus.o_Clear_Done); end
    foreach (addrs[i]) begin
      hostOp(1'b0, addrs[i], 3'd0);
      testsRun++; if (bus.o_Host_Rdata !== 3'b010) begin testsFailed++; $display("[TB] FAIL clear_rd[%0d]: got %0h expected 2", addrs[i], bus.o_Host_Rdata); end
    end
  endtask

  task automatic test_clear_disp();
    int n, dispCount, readyHigh;
    bus.i_Clear_Start = 1'b1; bus.i_Clear_Color = 3'b110;
    tick();
    bus.i_Clear_Start = 1'b0;
    bus.i_Host_Valid = 1'b1; bus.i_Host_We = 1'b0; bus.i_Host_Addr = 15'd0;
    bus.i_Disp_Addr = 15'd100;
    n = 0; dispCount = 0; readyHigh = 0;
    while (bus.o_Clear_Busy === 1'b1 && n < 25000) begin
      bus.i_Disp_Req = (n % 3 == 0) && (dispCount < 1000);
      if (bus.i_Disp_Req) dispCount++;
      bus.i_Clear_Start = (n == 5000);
      bus.i_Clear_Color = (n == 5000) ? 3'b001 : 3'b110;
      #1;
      if (bus.o_Host_Ready !== 1'b0) readyHigh++;
      tick();
      n++;
    end
    bus.i_Disp_Req = 1'b0; bus.i_Clear_Start = 1'b0;
    testsRun++; if (readyHigh != 0) begin testsFailed++; $display("[TB] FAIL clrdisp_ready_cycles: got %0d expected 0", readyHigh); end
    testsRun++; if (n != 20200) begin testsFailed++; $display("[TB] FAIL clrdisp_busy_cycles: got %0d expected 20200", n); end
    testsRun++; if (bus.o_Clear_Done !== 1'b1) begin testsFailed++; $display("[TB] FAIL clrdisp_done: got %0b expected 1", bus.o_Clear_Done); end
    tick();
    bus.i_Host_Valid = 1'b0;
    testsRun++; if (bus.o_Host_Rvalid !== 1'b1 || bus.o_Host_Rdata !== 3'b110) begin testsFailed++; $display("[TB] FAIL clrdisp_host_after: got valid %0b data %0h expected 1/6", bus.o_Host_Rvalid, bus.o_Host_Rdata); end
    hostOp(1'b0, 15'd19199, 3'd0);
    testsRun++; if (bus.o_Host_Rdata !== 3'b110) begin testsFailed++; $display("[TB] FAIL clrdisp_rd_last: got %0h expected 6", bus.o_Host_Rdata); end
  endtask

  task automatic test_reset_mid_clear();
    int doneSeen;
    bus.i_Clear_Start = 1'b1; bus.i_Clear_Color = 3'b011;
    tick();
    bus.i_Clear_Start = 1'b0;
    repeat (9600) tick();
    testsRun++; if (bus.o_Clear_Busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL midclr_busy_before: got %0b expected 1", bus.o_Clear_Busy); end
    rst_n = 1'b0;
    #1;
    testsRun++; if (bus.o_Clear_Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midclr_busy_async: got %0b expected 0", bus.o_Clear_Busy); end
    tick(); tick();
    rst_n = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.o_Clear_Done !== 1'b0 || bus.o_Clear_Busy !== 1'b0) doneSeen++;
    end
    testsRun++; if (doneSeen != 0) begin testsFailed++; $display("[TB] FAIL midclr_no_done: got %0d active cycles expected 0", doneSeen); end
    hostOp(1'b0, 15'd0, 3'd0);
    testsRun++; if (bus.o_Host_Rvalid !== 1'b1 || bus.o_Host_Rdata !== 3'b011) begin testsFailed++; $display("[TB] FAIL midclr_rd0: got valid %0b data %0h expected 1/3", bus.o_Host_Rvalid, bus.o_Host_Rdata); end
    hostOp(1'b0, 15'd19199, 3'd0);
    testsRun++; if (bus.o_Host_Rdata !== 3'b110) begin testsFailed++; $display("[TB] FAIL midclr_rd_untouched: got %0h expected 6", bus.o_Host_Rdata); end
  endtask

  task automatic test_out_of_range();
    bus.i_Host_Valid = 1'b1; bus.i_Host_We = 1'b1; bus.i_Host_Addr = 15'd19200; bus.i_Host_Wdata = 3'b111;
    #1;
    testsRun++; if (bus.o_Host_Ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL oor_write_ready: got %0b expected 1", bus.o_Host_Ready); end
    tick();
    bus.i_Host_Valid = 1'b0;
    hostOp(1'b0, 15'd19199, 3'd0);
    testsRun++; if (bus.o_Host_Rdata !== 3'b110) begin testsFailed++; $display("[TB] FAIL oor_rd_last: got %0h expected 6", bus.o_Host_Rdata); end
    hostOp(1'b0, 15'd19200, 3'd0);
    testsRun++; if (bus.o_Host_Rvalid !== 1'b1 || bus.o_Host_Rdata !== 3'd0) begin testsFailed++; $display("[TB] FAIL oor_rd19200: got valid %0b data %0h expected 1/0", bus.o_Host_Rvalid, bus.o_Host_Rdata); end
    hostOp(1'b0, 15'd19199, 3'd0);
    testsRun++; if (bus.o_Host_Rdata !== 3'b110) begin testsFailed++; $display("[TB] FAIL oor_rd_last_again: got %0h expected 6", bus.o_Host_Rdata); end
    hostOp(1'b0, 15'h7fff, 3'd0);
    testsRun++; if (bus.o_Host_Rvalid !== 1'b1 || bus.o_Host_Rdata !== 3'd0) begin testsFailed++; $display("[TB] FAIL oor_rd_max: got valid %0b data %0h expected 1/0", bus.o_Host_Rvalid, bus.o_Host_Rdata); end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_host_rw();
    test_disp_priority();
    test_back_to_back();
    test_clear();
    test_clear_disp();
    test_reset_mid_clear();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
